// File: rtl/v_upd_issue_pkg.sv
// Shared types for the list update bus: payload fields, the packed update word and issue FSM states.
package v_upd_issue_pkg;

  typedef logic [7:0]  id_t;
  typedef logic [1:0]  cmd_t;
  typedef logic [15:0] key_t;
  typedef logic [7:0]  size_t;

  typedef struct packed {
    id_t   prod_id;
    cmd_t  cmd;
    key_t  key;
    size_t size;
  } upd_t;

  localparam int UPD_ISSUE_GAP = 1;
  localparam int GAP_W         = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } issue_st_t;

endpackage

// File: rtl/v_upd_issue_if.sv
// Request side (producer -> issuer) and update side (issuer -> v) of the update path.
interface v_upd_issue_if;
  import v_upd_issue_pkg::*;

  logic req_vld;
  logic req_rdy;
  upd_t req;
  logic busy_r;
  logic upd_vld;
  upd_t upd;

  modport slave (
    input  req_vld, req, busy_r,
    output req_rdy, upd_vld, upd
  );

  modport master (
    output req_vld, req, busy_r,
    input  req_rdy, upd_vld, upd
  );

endinterface

// File: rtl/v_upd_issue_fifo.sv
// Flop-based DEPTH-entry FIFO of update words; head is visible combinationally from the read pointer.
// Level is a separate counter so full/empty never alias; full is registered from the next level.
module v_upd_issue_fifo
  import v_upd_issue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  upd_t                   i_push_dat,
  input  logic                   i_pop,
  output upd_t                   o_head,
  output logic [$clog2(DEPTH):0] o_level,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int          PW       = $clog2(DEPTH);
  localparam logic [PW:0] FULL_LVL = DEPTH;
  localparam logic [PW:0] ONE_LVL  = 1;

  upd_t          r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_level;
  logic [PW:0]   w_level_nxt;
  logic          r_full;

  always_comb begin
    w_level_nxt = r_level;
    if (i_push && !i_pop) begin
      w_level_nxt = r_level + ONE_LVL;
    end else if (!i_push && i_pop) begin
      w_level_nxt = r_level - ONE_LVL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == FULL_LVL);
    end
  end

  // Storage is not reset: contents are only observed through valid level.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_push_dat;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_level = r_level;
  assign o_full  = r_full;
  assign o_empty = (r_level == '0);

endmodule

// File: rtl/v_upd_issue.sv
// Buffers update requests and issues them to v as registered single-cycle pulses, held off by
// v's busy and by a minimum gap; request path is ready whenever the FIFO is not full.
module v_upd_issue
  import v_upd_issue_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int ISSUE_GAP = UPD_ISSUE_GAP
) (
  input  logic                   clk,
  input  logic                   rst,
  v_upd_issue_if.slave           bus,
  output logic [$clog2(DEPTH):0] o_level_r,
  output logic                   o_busy_r
);

  localparam logic [GAP_W-1:0] GAP_LD  = GAP_W'(ISSUE_GAP);
  localparam logic [GAP_W-1:0] GAP_ONE = GAP_W'(1);

  issue_st_t        r_state;
  issue_st_t        w_state_nxt;
  logic [GAP_W-1:0] r_gap_cnt;
  logic             r_rdy_en;
  upd_t             r_upd;
  upd_t             w_head;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;

  assign w_push = bus.req_vld & bus.req_rdy;

  v_upd_issue_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_push_dat (bus.req),
    .i_pop      (w_pop),
    .o_head     (w_head),
    .o_level    (o_level_r),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  // Only IDLE may issue, which already implies no pulse in flight and an expired gap.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty && !bus.busy_r) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_state_nxt = (GAP_LD != '0) ? ST_GAP : ST_IDLE;
      end
      ST_GAP: begin
        if (r_gap_cnt <= GAP_ONE) w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_gap_cnt <= '0;
      r_upd     <= '0;
      r_rdy_en  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_rdy_en <= 1'b1;
      if (w_pop) r_upd <= w_head;
      if (r_state == ST_ISSUE) begin
        r_gap_cnt <= GAP_LD;
      end else if (r_gap_cnt != '0) begin
        r_gap_cnt <= r_gap_cnt - GAP_ONE;
      end
    end
  end

  assign bus.req_rdy = r_rdy_en & ~w_full;
  assign bus.upd_vld = (r_state == ST_ISSUE);
  assign bus.upd     = r_upd;
  assign o_busy_r    = ~w_empty | (r_state == ST_ISSUE) | (r_gap_cnt != '0);

endmodule

// File: tb/tb_v_upd_issue.sv
// Directed and randomized bench for v_upd_issue (DEPTH=4, ISSUE_GAP=1).
module tb_v_upd_issue;
  import v_upd_issue_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] level;
  logic       busy;
  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  int         idx;
  int         last;
  int         nb;
  logic       held;
  logic       acc;
  upd_t       p [5];
  upd_t       sb [$];
  upd_t       exp_u;

  v_upd_issue_if bus ();

  v_upd_issue #(
    .DEPTH     (4),
    .ISSUE_GAP (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .o_level_r (level),
    .o_busy_r  (busy)
  );

  always #5 clk = ~clk;

  function automatic upd_t mk(input int id, input int cmd, input int key, input int sz);
    upd_t u;
    u.prod_id = id_t'(id);
    u.cmd     = cmd_t'(cmd);
    u.key     = key_t'(key);
    u.size    = size_t'(sz);
    return u;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    rst         = 1'b1;
    bus.req_vld = 1'b0;
    bus.req     = '0;
    bus.busy_r  = 1'b0;

    // reset state
    tick();
    tick();
    chk("rst_rdy",   64'(bus.req_rdy), 64'(0));
    chk("rst_vld",   64'(bus.upd_vld), 64'(0));
    chk("rst_level", 64'(level),       64'(0));
    chk("rst_busy",  64'(busy),        64'(0));
    chk("rst_upd",   64'(bus.upd),     64'(0));
    rst = 1'b0;
    tick();
    chk("rst_rdy_after", 64'(bus.req_rdy), 64'(1));

    // 1: single push, issue two cycles later, busy clears after the gap
    while (cyc < 10) tick();
    p[0] = mk(3, 1, 'h100, 5);
    bus.req_vld = 1'b1;
    bus.req     = p[0];
    tick();
    bus.req_vld = 1'b0;
    chk("t1_vld_n1",   64'(bus.upd_vld), 64'(0));
    chk("t1_level_n1", 64'(level),       64'(1));
    tick();
    chk("t1_vld_n2",   64'(bus.upd_vld), 64'(1));
    chk("t1_upd_n2",   64'(bus.upd),     64'(p[0]));
    tick();
    chk("t1_vld_n3",   64'(bus.upd_vld), 64'(0));
    chk("t1_busy_n3",  64'(busy),        64'(1));
    chk("t1_hold_n3",  64'(bus.upd),     64'(p[0]));
    tick();
    chk("t1_busy_n4",  64'(busy),        64'(0));

    // 2: four back-to-back pushes, issues at +2,+5,+8,+11
    for (int i = 0; i < 4; i++) p[i] = mk(16 + i, i, 'h200 + i, 40 + i);
    idx = 0;
    for (int k = 0; k < 14; k++) begin
      chk("t2_rdy", 64'(bus.req_rdy), 64'(1));
      if (k < 4) begin
        bus.req_vld = 1'b1;
        bus.req     = p[k];
      end else begin
        bus.req_vld = 1'b0;
      end
      tick();
      chk("t2_vld", 64'(bus.upd_vld), 64'((k + 1 == 2) || (k + 1 == 5) || (k + 1 == 8) || (k + 1 == 11)));
      if (bus.upd_vld && idx < 4) begin
        chk("t2_upd", 64'(bus.upd), 64'(p[idx]));
        idx++;
      end
    end
    chk("t2_count", 64'(idx), 64'(4));
    tick();
    tick();

    // 3: fill while v is busy, fifth request held until the first pop
    for (int i = 0; i < 5; i++) p[i] = mk(32 + i, 3 - (i % 4), 'h300 + i, 60 + i);
    bus.busy_r = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.req_vld = 1'b1;
      bus.req     = p[k];
      chk("t3_rdy_fill", 64'(bus.req_rdy), 64'(1));
      tick();
    end
    bus.req = p[4];
    chk("t3_rdy_full",   64'(bus.req_rdy), 64'(0));
    chk("t3_level_full", 64'(level),       64'(4));
    tick();
    chk("t3_rdy_full2",  64'(bus.req_rdy), 64'(0));
    chk("t3_vld_busy",   64'(bus.upd_vld), 64'(0));
    bus.busy_r = 1'b0;
    tick();
    chk("t3_vld_first",  64'(bus.upd_vld), 64'(1));
    chk("t3_upd_first",  64'(bus.upd),     64'(p[0]));
    chk("t3_rdy_back",   64'(bus.req_rdy), 64'(1));
    chk("t3_level_pop",  64'(level),       64'(3));
    last = cyc;
    tick();
    bus.req_vld = 1'b0;
    chk("t3_level_push5", 64'(level),       64'(4));
    chk("t3_rdy_again",   64'(bus.req_rdy), 64'(0));
    idx = 1;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (bus.upd_vld) begin
        chk("t3_gap", 64'((cyc - last) >= 3), 64'(1));
        if (idx < 5) chk("t3_upd_order", 64'(bus.upd), 64'(p[idx]));
        idx++;
        last = cyc;
      end
    end
    chk("t3_count", 64'(idx), 64'(5));
    chk("t3_idle",  64'(busy), 64'(0));

    // 4: busy toggles every cycle with three queued
    for (int i = 0; i < 3; i++) p[i] = mk(48 + i, i + 1, 'h400 + i, 80 + i);
    bus.busy_r = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.req_vld = 1'b1;
      bus.req     = p[k];
      tick();
    end
    bus.req_vld = 1'b0;
    idx = 0;
    for (int k = 0; k < 30; k++) begin
      bus.busy_r = (k % 2 == 0);
      nb = int'(bus.busy_r);
      tick();
      if (bus.upd_vld) begin
        chk("t4_busy_prev", 64'(nb), 64'(0));
        if (idx < 3) chk("t4_upd_order", 64'(bus.upd), 64'(p[idx]));
        idx++;
      end
    end
    bus.busy_r = 1'b0;
    chk("t4_count", 64'(idx), 64'(3));
    tick();
    tick();
    tick();
    chk("t4_idle", 64'(busy), 64'(0));

    // 5: reset during the gap drops the queue
    for (int k = 0; k < 3; k++) begin
      bus.req_vld = 1'b1;
      bus.req     = mk(64 + k, 2, 'h500 + k, 90 + k);
      tick();
    end
    bus.req_vld = 1'b0;
    chk("t5_pre_vld",  64'(bus.upd_vld), 64'(0));
    chk("t5_pre_busy", 64'(busy),        64'(1));
    rst = 1'b1;
    tick();
    chk("t5_rst_level", 64'(level),       64'(0));
    chk("t5_rst_vld",   64'(bus.upd_vld), 64'(0));
    chk("t5_rst_busy",  64'(busy),        64'(0));
    chk("t5_rst_rdy",   64'(bus.req_rdy), 64'(0));
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t5_post_vld",   64'(bus.upd_vld), 64'(0));
      chk("t5_post_level", 64'(level),       64'(0));
    end
    chk("t5_post_rdy", 64'(bus.req_rdy), 64'(1));
    exp_u = mk(7, 3, 'hBEEF, 200);
    bus.req_vld = 1'b1;
    bus.req     = exp_u;
    tick();
    bus.req_vld = 1'b0;
    chk("t5_fresh_vld_n1", 64'(bus.upd_vld), 64'(0));
    tick();
    chk("t5_fresh_vld_n2", 64'(bus.upd_vld), 64'(1));
    chk("t5_fresh_upd",    64'(bus.upd),     64'(exp_u));
    tick();
    tick();

    // 6: random push/busy against a scoreboard
    held = 1'b0;
    last = -100;
    for (int k = 0; k < 10000; k++) begin
      if (!held) begin
        bus.req_vld = ($urandom_range(0, 1) == 1);
        bus.req     = mk($urandom, $urandom, $urandom, $urandom);
      end
      bus.busy_r = ($urandom_range(0, 2) == 0);
      nb  = int'(bus.busy_r);
      acc = bus.req_vld && bus.req_rdy;
      if (acc) sb.push_back(bus.req);
      tick();
      held = bus.req_vld && !acc;
      if (bus.upd_vld) begin
        chk("t6_busy_prev", 64'(nb), 64'(0));
        chk("t6_gap", 64'((cyc - last) >= 3), 64'(1));
        chk("t6_sb_nonempty", 64'(sb.size() != 0), 64'(1));
        if (sb.size() != 0) begin
          exp_u = sb.pop_front();
          chk("t6_upd", 64'(bus.upd), 64'(exp_u));
        end
        last = cyc;
      end
    end
    bus.req_vld = 1'b0;
    bus.busy_r  = 1'b0;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (bus.upd_vld) begin
        chk("t6_drain_gap", 64'((cyc - last) >= 3), 64'(1));
        chk("t6_drain_sb_nonempty", 64'(sb.size() != 0), 64'(1));
        if (sb.size() != 0) begin
          exp_u = sb.pop_front();
          chk("t6_drain_upd", 64'(bus.upd), 64'(exp_u));
        end
        last = cyc;
      end
    end
    chk("t6_sb_empty", 64'(sb.size()), 64'(0));
    chk("t6_level",    64'(level),     64'(0));
    chk("t6_busy",     64'(busy),      64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
